// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the two-requester memory port arbiter: CPU port, IO-engine port,
// the shared memory port and the arbiter status flags.
interface mem_port_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 15
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [WIDTH-1:0]  cpu_wdata;
    logic              cpu_ack;
    logic              cpu_err;
    logic [WIDTH-1:0]  cpu_rdata;

    logic              io_req;
    logic              io_we;
    logic [ADDR_W-1:0] io_addr;
    logic [WIDTH-1:0]  io_wdata;
    logic              io_ack;
    logic              io_err;
    logic [WIDTH-1:0]  io_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;

    logic              busy;
    logic              grant_id;

    // Arbiter side of the bundle
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_err, cpu_rdata,
        input  io_req, io_we, io_addr, io_wdata,
        output io_ack, io_err, io_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, grant_id
    );

    // Requesters plus memory side of the bundle
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_err, cpu_rdata,
        output io_req, io_we, io_addr, io_wdata,
        input  io_ack, io_err, io_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, grant_id
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-cycle memory port between a CPU and an
// IO engine, with alignment, range and MMIO-window checking per transaction.
module mem_port_arbiter #(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 15,
    parameter int MEM_BYTES = 26260,
    parameter int MMIO_BASE = 7368,
    parameter int MMIO_LAST = 7523
) (
    input logic           clk,
    input logic           rst_n,
    mem_port_arbiter_if.slave bus
);
    // Highest legal word-start addresses, widened so comparisons never truncate
    localparam logic [31:0] MEM_TOP = 32'(MEM_BYTES - 4);
    localparam logic [31:0] MMIO_LO = 32'(MMIO_BASE);
    localparam logic [31:0] MMIO_HI = 32'(MMIO_LAST - 3);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              owner;
    logic              owner_next;
    logic              we_q;
    logic              we_next;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_next;
    logic [WIDTH-1:0]  wdata_q;
    logic [WIDTH-1:0]  wdata_next;
    logic              err_q;
    logic              err_next;
    logic [WIDTH-1:0]  cpu_rdata_q;
    logic [WIDTH-1:0]  io_rdata_q;
    logic [31:0]       addr_wide;
    logic              addr_bad;
    logic              pick_io;
    logic              read_done;

    assign addr_wide = 32'(addr_q);
    assign read_done = (state == RESP) && !err_q && !we_q;

    always_comb begin
        addr_bad = 1'b0;
        if (addr_q[1:0] != 2'b00) begin
            addr_bad = 1'b1;
        end
        if (addr_wide > MEM_TOP) begin
            addr_bad = 1'b1;
        end
        if (owner && ((addr_wide < MMIO_LO) || (addr_wide > MMIO_HI))) begin
            addr_bad = 1'b1;
        end
    end

    // On a tie the requester that did not own the previous transaction wins
    always_comb begin
        pick_io = bus.io_req;
        if (bus.cpu_req && bus.io_req) begin
            pick_io = ~owner;
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        we_next    = we_q;
        addr_next  = addr_q;
        wdata_next = wdata_q;
        err_next   = err_q;
        case (state)
            IDLE: begin
                if (bus.cpu_req || bus.io_req) begin
                    owner_next = pick_io;
                    we_next    = pick_io ? bus.io_we    : bus.cpu_we;
                    addr_next  = pick_io ? bus.io_addr  : bus.cpu_addr;
                    wdata_next = pick_io ? bus.io_wdata : bus.cpu_wdata;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                err_next   = addr_bad;
                state_next = addr_bad ? RESP : ACCESS;
            end
            ACCESS: begin
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Owner resets to IO so the very first tie goes to the CPU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_next;
            owner   <= owner_next;
            we_q    <= we_next;
            addr_q  <= addr_next;
            wdata_q <= wdata_next;
            err_q   <= err_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata_q <= '0;
            io_rdata_q  <= '0;
        end else if (read_done) begin
            if (owner) begin
                io_rdata_q <= bus.mem_rdata;
            end else begin
                cpu_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = (state == ACCESS);
    assign bus.mem_we    = (state == ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.busy      = (state != IDLE);
    assign bus.grant_id  = owner;

    assign bus.cpu_ack   = (state == RESP) && !owner;
    assign bus.cpu_err   = (state == RESP) && !owner && err_q;
    assign bus.io_ack    = (state == RESP) && owner;
    assign bus.io_err    = (state == RESP) && owner && err_q;

    // Read data is forwarded straight from memory during the ack cycle, then held
    assign bus.cpu_rdata = (read_done && !owner) ? bus.mem_rdata : cpu_rdata_q;
    assign bus.io_rdata  = (read_done && owner)  ? bus.mem_rdata : io_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed corner cases plus random
// transactions scored against a transaction-level model of arbitration and checking.
module tb_mem_port_arbiter;
    localparam int WIDTH     = 32;
    localparam int ADDR_W    = 15;
    localparam int MEM_BYTES = 26260;
    localparam int MMIO_BASE = 7368;
    localparam int MMIO_LAST = 7523;
    localparam int WORDS     = MEM_BYTES / 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES),
        .MMIO_BASE(MMIO_BASE), .MMIO_LAST(MMIO_LAST)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    // Memory behind the port: data appears the cycle after the strobe
    logic [31:0] mem_array [0:WORDS-1];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem_array[bus.mem_addr[ADDR_W-1:2]] <= bus.mem_wdata;
            end else begin
                bus.mem_rdata <= mem_array[bus.mem_addr[ADDR_W-1:2]];
            end
        end
    end

    // Reference model state
    logic [31:0] shadow [0:WORDS-1];
    bit          last_grant;
    logic [31:0] exp_cpu_rdata;
    logic [31:0] exp_io_rdata;
    int          checks = 0;
    int          errors = 0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input bit io_owner, input int addr);
        bit bad;
        bad = (addr % 4) != 0;
        if (addr > MEM_BYTES - 4) bad = 1'b1;
        if (io_owner && (addr < MMIO_BASE || addr > MMIO_LAST - 3)) bad = 1'b1;
        return bad;
    endfunction

    function automatic int rand_addr();
        int edges [8];
        edges = '{0, 7364, 7368, 7520, 7524, 26256, 26258, 26260};
        case ($urandom_range(0, 3))
            0:       return MMIO_BASE + 4 * int'($urandom_range(0, 38));
            1:       return 4 * int'($urandom_range(0, WORDS - 1));
            2:       return int'($urandom_range(0, 32767));
            default: return edges[$urandom_range(0, 7)];
        endcase
    endfunction

    // One transaction: start and end on a falling edge with the arbiter idle
    task automatic apply_stimulus(input bit c_req, input bit c_we, input int c_addr, input logic [31:0] c_data,
                                  input bit i_req, input bit i_we, input int i_addr, input logic [31:0] i_data,
                                  input bit drop, input bit keep);
        bit          winner;
        bit          exp_we;
        int          exp_addr;
        logic [31:0] exp_data;
        bit          exp_err;
        int          exp_lat;
        int          lat;
        int          en_cnt;
        bit          seen;
        winner   = (c_req && i_req) ? !last_grant : i_req;
        exp_we   = winner ? i_we : c_we;
        exp_addr = winner ? i_addr : c_addr;
        exp_data = winner ? i_data : c_data;
        exp_err  = model_err(winner, exp_addr);
        exp_lat  = exp_err ? 2 : 3;
        lat      = 0;
        en_cnt   = 0;
        seen     = 1'b0;
        if (!exp_err) begin
            if (exp_we) shadow[exp_addr / 4] = exp_data;
            else if (winner) exp_io_rdata = shadow[exp_addr / 4];
            else exp_cpu_rdata = shadow[exp_addr / 4];
        end

        bus.cpu_req = c_req; bus.cpu_we = c_we; bus.cpu_addr = ADDR_W'(c_addr); bus.cpu_wdata = c_data;
        bus.io_req  = i_req; bus.io_we  = i_we; bus.io_addr  = ADDR_W'(i_addr); bus.io_wdata  = i_data;
        @(posedge clk);
        last_grant = winner;

        for (int cyc = 1; cyc <= 6 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check_output("grant_id", 32'(bus.grant_id), 32'(winner));
                if (!keep) begin
                    if (winner) begin
                        bus.io_addr = ADDR_W'($urandom); bus.io_wdata = $urandom; bus.io_we = ~bus.io_we;
                        if (drop) bus.io_req = 1'b0;
                    end else begin
                        bus.cpu_addr = ADDR_W'($urandom); bus.cpu_wdata = $urandom; bus.cpu_we = ~bus.cpu_we;
                        if (drop) bus.cpu_req = 1'b0;
                    end
                end
            end
            check_output("busy_in_txn", 32'(bus.busy), 32'd1);
            if (bus.mem_en) begin
                en_cnt++;
                check_output("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
                check_output("mem_we", 32'(bus.mem_we), 32'(exp_we));
                if (exp_we) check_output("mem_wdata", bus.mem_wdata, exp_data);
            end
            check_output("nonowner_ack", 32'(winner ? bus.cpu_ack : bus.io_ack), 32'd0);
            check_output("nonowner_err", 32'(winner ? bus.cpu_err : bus.io_err), 32'd0);
            if (winner ? bus.io_ack : bus.cpu_ack) begin
                seen = 1'b1;
                lat  = cyc;
                check_output("owner_err", 32'(winner ? bus.io_err : bus.cpu_err), 32'(exp_err));
                check_output("owner_rdata", winner ? bus.io_rdata : bus.cpu_rdata,
                             winner ? exp_io_rdata : exp_cpu_rdata);
            end
        end
        check_output("ack_seen", 32'(seen), 32'd1);
        check_output("ack_latency", 32'(lat), 32'(exp_lat));
        check_output("mem_en_count", 32'(en_cnt), exp_err ? 32'd0 : 32'd1);

        @(negedge clk);
        check_output("busy_idle", 32'(bus.busy), 32'd0);
        check_output("mem_en_idle", 32'(bus.mem_en), 32'd0);
        check_output("acks_idle", 32'({bus.cpu_ack, bus.io_ack}), 32'd0);
        check_output("cpu_rdata_hold", bus.cpu_rdata, exp_cpu_rdata);
        check_output("io_rdata_hold", bus.io_rdata, exp_io_rdata);
        if (!keep) begin
            bus.cpu_req = 1'b0;
            bus.io_req  = 1'b0;
        end
        if (drop && !keep) begin
            @(negedge clk);
            check_output("no_second_txn", 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_output({tag, "_grant"}, 32'(bus.grant_id), 32'd1);
        check_output({tag, "_acks_errs"}, 32'({bus.cpu_ack, bus.cpu_err, bus.io_ack, bus.io_err}), 32'd0);
        check_output({tag, "_mem_strobes"}, 32'({bus.mem_en, bus.mem_we}), 32'd0);
        check_output({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check_output({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        check_output({tag, "_cpu_rdata"}, bus.cpu_rdata, 32'd0);
        check_output({tag, "_io_rdata"}, bus.io_rdata, 32'd0);
    endtask

    initial begin
        int sel;
        bit cr;
        bit ir;
        logic [31:0] v;
        for (int i = 0; i < WORDS; i++) begin
            v = $urandom;
            mem_array[i] = v;
            shadow[i]    = v;
        end
        mem_array[32'h100 / 4] = 32'hDEADBEEF;
        shadow[32'h100 / 4]    = 32'hDEADBEEF;
        last_grant    = 1'b1;
        exp_cpu_rdata = '0;
        exp_io_rdata  = '0;

        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.io_req  = 0; bus.io_we  = 0; bus.io_addr  = '0; bus.io_wdata  = '0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        $display("[TB] tie from reset, both held: CPU, IO, CPU");
        apply_stimulus(1, 0, 32'h200, 0, 1, 0, 7400, 0, 0, 1);
        apply_stimulus(1, 0, 32'h200, 0, 1, 0, 7400, 0, 0, 1);
        apply_stimulus(1, 0, 32'h200, 0, 1, 0, 7400, 0, 0, 0);

        $display("[TB] directed reads, writes and address checks");
        apply_stimulus(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 1, 1, 7368, 32'h00FF00FF, 0, 0);
        apply_stimulus(0, 0, 0, 0, 1, 1, 32'h100, 32'h12345678, 0, 0);
        apply_stimulus(0, 0, 0, 0, 1, 0, 7368, 0, 0, 0);
        apply_stimulus(1, 0, 32'h102, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 26258, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 26256, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 26260, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 1, 0, 7520, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 1, 0, 7524, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 1, 0, 7364, 0, 0, 0);
        apply_stimulus(1, 0, 32'h100, 0, 0, 0, 0, 0, 1, 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 2));
            cr  = (sel != 1);
            ir  = (sel != 0);
            apply_stimulus(cr, 1'($urandom), rand_addr(), $urandom,
                           ir, 1'($urandom), rand_addr(), $urandom,
                           $urandom_range(0, 3) == 0, 0);
        end

        $display("[TB] reset during memory access");
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = ADDR_W'(32'h100);
        bus.io_req  = 0;
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req = 0;
        @(posedge clk);
        @(negedge clk);
        check_output("abort_in_access", 32'(bus.mem_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output("abort_no_ack", 32'({bus.cpu_ack, bus.io_ack}), 32'd0);
        end
        last_grant    = 1'b1;
        exp_cpu_rdata = '0;
        exp_io_rdata  = '0;
        rst_n = 1'b1;
        apply_stimulus(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
